// File: rtl/mpu_sample_sequencer.sv
// MPU6050 wake-up write, then a periodic 6-byte accel burst read assembled into signed ax/ay/az.
// Sample is published 1 cycle after xfer_done; requests hold until req_ready, and ticks that arrive while busy are dropped.
module mpu_sample_sequencer #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SAMPLE_RATE_HZ = 50,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [7:0]         req_reg,
  output logic [7:0]         req_wdata,
  output logic [2:0]         req_len,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               xfer_done,
  input  logic               xfer_err,
  output logic               xfer_abort,
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
  output logic signed [15:0] az,
  output logic               data_valid,
  output logic               init_done,
  output logic               sample_missed,
  output logic [7:0]         err_count
);
  localparam int PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int TW     = $clog2(PERIOD);
  localparam int OW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT_REQ, S_INIT_WAIT, S_INIT_HOLD, S_IDLE, S_RD_REQ, S_RD_COLLECT, S_PUBLISH
  } state_t;

  state_t             r_state;
  logic [TW-1:0]      r_tick_cnt;
  logic [OW-1:0]      r_to_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shadow [0:5];
  logic               r_req_valid;
  logic               r_req_write;
  logic [7:0]         r_req_reg;
  logic [7:0]         r_req_wdata;
  logic [2:0]         r_req_len;
  logic               r_xfer_abort;
  logic signed [15:0] r_ax, r_ay, r_az;
  logic               r_data_valid;
  logic               r_init_done;
  logic               r_sample_missed;
  logic [7:0]         r_err_count;

  logic       w_tick;
  logic       w_timeout;
  logic       w_busy;
  logic [2:0] w_byte_cnt;
  logic [7:0] w_azl;
  logic [7:0] w_err_sat;

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_timeout  = (r_to_cnt == TO_LAST);
  assign w_busy     = (r_state == S_RD_REQ) || (r_state == S_RD_COLLECT) || (r_state == S_PUBLISH);
  assign w_byte_cnt = r_idx + {2'b00, rx_valid};
  // The final byte may land in the same cycle as xfer_done.
  assign w_azl      = (rx_valid && r_idx == 3'd5) ? rx_data : r_shadow[5];
  assign w_err_sat  = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_INIT_REQ;
      r_tick_cnt      <= '0;
      r_to_cnt        <= '0;
      r_idx           <= '0;
      for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
      r_req_valid     <= 1'b0;
      r_req_write     <= 1'b0;
      r_req_reg       <= '0;
      r_req_wdata     <= '0;
      r_req_len       <= '0;
      r_xfer_abort    <= 1'b0;
      r_ax            <= '0;
      r_ay            <= '0;
      r_az            <= '0;
      r_data_valid    <= 1'b0;
      r_init_done     <= 1'b0;
      r_sample_missed <= 1'b0;
      r_err_count     <= '0;
    end else begin
      r_xfer_abort    <= 1'b0;
      r_data_valid    <= 1'b0;
      r_sample_missed <= 1'b0;
      r_tick_cnt      <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick && r_init_done && w_busy) r_sample_missed <= 1'b1;

      case (r_state)
        S_INIT_REQ: begin
          if (!r_req_valid) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b1;
            r_req_reg   <= 8'h6B;
            r_req_wdata <= 8'h00;
          end else if (req_ready) begin
            r_req_valid <= 1'b0;
            r_to_cnt    <= OW'(1);
            r_state     <= S_INIT_WAIT;
          end
        end
        S_INIT_WAIT: begin
          if (xfer_done) begin
            if (!xfer_err) begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_err_count <= w_err_sat;
              r_state     <= S_INIT_HOLD;
            end
          end else if (w_timeout) begin
            r_xfer_abort <= 1'b1;
            r_err_count  <= w_err_sat;
            r_state      <= S_INIT_HOLD;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_INIT_HOLD: begin
          if (w_tick) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b1;
            r_req_reg   <= 8'h6B;
            r_req_wdata <= 8'h00;
            r_state     <= S_INIT_REQ;
          end
        end
        S_IDLE: begin
          if (w_tick) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b0;
            r_req_reg   <= 8'h3B;
            r_req_len   <= 3'd6;
            r_state     <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_idx       <= '0;
            r_to_cnt    <= OW'(1);
            r_state     <= S_RD_COLLECT;
          end
        end
        S_RD_COLLECT: begin
          if (rx_valid && r_idx < 3'd6) r_shadow[r_idx] <= rx_data;
          if (rx_valid && r_idx != 3'd7) r_idx <= r_idx + 3'd1;
          if (rx_valid && r_idx == 3'd6) begin
            r_err_count <= w_err_sat;
            r_state     <= S_IDLE;
          end else if (xfer_done) begin
            if (!xfer_err && w_byte_cnt == 3'd6) begin
              r_ax         <= {r_shadow[0], r_shadow[1]};
              r_ay         <= {r_shadow[2], r_shadow[3]};
              r_az         <= {r_shadow[4], w_azl};
              r_data_valid <= 1'b1;
              r_state      <= S_PUBLISH;
            end else begin
              r_err_count <= w_err_sat;
              r_state     <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_xfer_abort <= 1'b1;
            r_err_count  <= w_err_sat;
            r_state      <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_PUBLISH: r_state <= S_IDLE;
        default:   r_state <= S_INIT_REQ;
      endcase
    end
  end

  assign req_valid     = r_req_valid;
  assign req_write     = r_req_write;
  assign req_reg       = r_req_reg;
  assign req_wdata     = r_req_wdata;
  assign req_len       = r_req_len;
  assign xfer_abort    = r_xfer_abort;
  assign ax            = r_ax;
  assign ay            = r_ay;
  assign az            = r_az;
  assign data_valid    = r_data_valid;
  assign init_done     = r_init_done;
  assign sample_missed = r_sample_missed;
  assign err_count     = r_err_count;
endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// Directed-plus-random bench for mpu_sample_sequencer: PERIOD=100, TIMEOUT_CYCLES=50.
module tb_mpu_sample_sequencer;
  localparam int PER = 100;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst, req_ready, rx_valid, xfer_done, xfer_err;
  logic [7:0] rx_data;
  logic req_valid, req_write, xfer_abort, data_valid, init_done, sample_missed;
  logic [7:0] req_reg, req_wdata, err_count;
  logic [2:0] req_len;
  logic signed [15:0] ax, ay, az;

  always #5 clk = ~clk;

  mpu_sample_sequencer #(.CLK_FREQ_HZ(1000), .SAMPLE_RATE_HZ(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_len(req_len), .rx_valid(rx_valid),
    .rx_data(rx_data), .xfer_done(xfer_done), .xfer_err(xfer_err), .xfer_abort(xfer_abort),
    .ax(ax), .ay(ay), .az(az), .data_valid(data_valid), .init_done(init_done),
    .sample_missed(sample_missed), .err_count(err_count)
  );

  int total = 0, bad = 0;
  int t = 0, t_acc = 0;
  int n_dv = 0, n_miss = 0, n_abort = 0, n_req = 0;
  logic prev_rv = 1'b0;
  logic [7:0] b [6];
  logic signed [15:0] exp_ax, exp_ay, exp_az;
  int exp_err;

  // Pulse counters, sampled on the falling edge so each registered pulse is seen once.
  always @(negedge clk) begin
    if (data_valid)    n_dv    <= n_dv + 1;
    if (sample_missed) n_miss  <= n_miss + 1;
    if (xfer_abort)    n_abort <= n_abort + 1;
    if (req_valid && !prev_rv) n_req <= n_req + 1;
    prev_rv <= req_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_req(input int max_steps);
    for (int k = 0; k < max_steps && !req_valid; k++) step();
    chk("req_seen", {31'b0, req_valid}, 32'd1);
  endtask

  task automatic accept(input int delay);
    repeat (delay) step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    t_acc = t;
  endtask

  task automatic send_bytes(input int n);
    for (int j = 0; j < n; j++) begin
      rx_valid = 1'b1;
      rx_data  = b[j];
      step();
    end
    rx_valid = 1'b0;
  endtask

  task automatic done(input logic e);
    xfer_done = 1'b1;
    xfer_err  = e;
    step();
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
  endtask

  task automatic expect_sample(input string tag);
    chk({tag, "_dv"}, {31'b0, data_valid}, 32'd1);
    chk({tag, "_ax"}, ax, exp_ax);
    chk({tag, "_ay"}, ay, exp_ay);
    chk({tag, "_az"}, az, exp_az);
  endtask

  initial begin
    int dv0, miss0, ab0, req0, unstable;
    rst = 1'b1; req_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    xfer_done = 1'b0; xfer_err = 1'b0;
    repeat (3) step();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_outs", {ax, ay}, 32'd0);
    chk("rst_misc", {az, err_count, 5'b0, init_done, data_valid, xfer_abort}, 32'd0);

    // Wake-up write succeeds, first read on tick 100.
    rst = 1'b0; t = 0; exp_err = 0;
    step();
    chk("init_req", {req_valid, req_write, req_reg, req_wdata}, {2'b11, 8'h6B, 8'h00});
    accept(0);
    repeat (9) step();
    done(1'b0);
    chk("init_done", {31'b0, init_done}, 32'd1);
    while (t < PER - 1) step();
    chk("no_early_read", {31'b0, req_valid}, 32'd0);
    step();
    chk("first_read", {req_valid, req_write, req_reg, 5'b0, req_len}, {2'b10, 8'h3B, 8'h06});

    // Fixed sample from the plan.
    dv0 = n_dv;
    b[0] = 8'h61; b[1] = 8'hA8; b[2] = 8'h05; b[3] = 8'hDC; b[4] = 8'hFC; b[5] = 8'h18;
    exp_ax = 16'sd25000; exp_ay = 16'sd1500; exp_az = -16'sd1000;
    accept(2);
    send_bytes(6);
    done(1'b0);
    expect_sample("s2");
    step();
    chk("s2_dv_low", {31'b0, data_valid}, 32'd0);
    chk("s2_dv_once", n_dv - dv0, 32'd1);

    // Random good samples, one per tick.
    for (int i = 0; i < 4; i++) begin
      wait_req(2 * PER);
      chk("tick_align", t % PER, 32'd0);
      for (int j = 0; j < 6; j++) b[j] = 8'($urandom);
      exp_ax = {b[0], b[1]}; exp_ay = {b[2], b[3]}; exp_az = {b[4], b[5]};
      dv0 = n_dv;
      accept($urandom_range(0, 3));
      send_bytes(6);
      repeat ($urandom_range(0, 5)) step();
      done(1'b0);
      expect_sample("rnd");
      step();
      chk("rnd_dv_once", n_dv - dv0, 32'd1);
      chk("rnd_err", err_count, exp_err);
    end

    // Short read, then a NACKed read: both discarded.
    dv0 = n_dv;
    wait_req(2 * PER);
    accept(1);
    send_bytes(5);
    done(1'b0);
    exp_err++;
    wait_req(2 * PER);
    accept(0);
    done(1'b1);
    exp_err++;
    step();
    chk("s3_err", err_count, exp_err);
    chk("s3_no_dv", n_dv - dv0, 32'd0);
    chk("s3_hold", {ax, ay}, {exp_ax, exp_ay});
    chk("s3_hold_az", az, exp_az);

    // Timeout: abort lands TO cycles after the acceptance cycle.
    wait_req(2 * PER);
    ab0 = n_abort;
    accept(0);
    while (t < t_acc + TO - 2) step();
    step();
    chk("s4_no_early_abort", n_abort - ab0, 32'd0);
    chk("s4_abort", {31'b0, xfer_abort}, 32'd1);
    exp_err++;
    chk("s4_err", err_count, exp_err);
    step();
    chk("s4_abort_pulse", {31'b0, xfer_abort}, 32'd0);
    wait_req(2 * PER);
    chk("s4_retry_tick", t % PER, 32'd0);

    // xfer_done in the last cycle before the timeout wins.
    for (int j = 0; j < 6; j++) b[j] = 8'($urandom);
    exp_ax = {b[0], b[1]}; exp_ay = {b[2], b[3]}; exp_az = {b[4], b[5]};
    ab0 = n_abort;
    accept(0);
    send_bytes(6);
    while (t < t_acc + TO - 2) step();
    done(1'b0);
    expect_sample("s4_edge");
    repeat (3) step();
    chk("s4_edge_no_abort", n_abort - ab0, 32'd0);
    chk("s4_edge_err", err_count, exp_err);

    // Backpressure: request held 150 cycles across one tick.
    req0 = n_req;
    miss0 = n_miss;
    unstable = 0;
    wait_req(2 * PER);
    for (int k = 0; k < 150; k++) begin
      if ({req_valid, req_write, req_reg, req_len} !== {2'b10, 8'h3B, 3'd6}) unstable++;
      step();
    end
    chk("s5_stable", unstable, 32'd0);
    chk("s5_missed", n_miss - miss0, 32'd1);
    for (int j = 0; j < 6; j++) b[j] = 8'($urandom);
    exp_ax = {b[0], b[1]}; exp_ay = {b[2], b[3]}; exp_az = {b[4], b[5]};
    accept(0);
    send_bytes(6);
    done(1'b0);
    expect_sample("s5");
    step();
    chk("s5_one_req", n_req - req0, 32'd1);

    // Reset in the middle of collecting bytes.
    wait_req(2 * PER);
    accept(0);
    send_bytes(3);
    rst = 1'b1;
    step();
    chk("s6_rst_a", {ax, ay}, 32'd0);
    chk("s6_rst_b", {az, err_count, 4'b0, req_valid, init_done, data_valid, xfer_abort}, 32'd0);
    rst = 1'b0; t = 0;
    step();
    chk("s6_init_req", {req_valid, req_write, req_reg}, {2'b11, 8'h6B});

    // Failed wake-up write is retried on the next tick.
    accept(1);
    repeat (4) step();
    done(1'b1);
    chk("s6_init_err", err_count, 32'd1);
    chk("s6_not_init", {31'b0, init_done}, 32'd0);
    while (t < PER - 1) step();
    chk("s6_hold", {31'b0, req_valid}, 32'd0);
    step();
    chk("s6_retry", {req_valid, req_write, req_reg}, {2'b11, 8'h6B});
    accept(0);
    repeat (3) step();
    done(1'b0);
    chk("s6_init_done", {31'b0, init_done}, 32'd1);
    wait_req(2 * PER);
    chk("s6_read_tick", t, 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
